// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked adder with registered inter-slice carry
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_merged;
    logic             cy;
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] pos;
    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK-1:0] slice;
    logic             cy_next;
    logic             ovf_next;
    logic             last;

    assign pos  = POS_W'(int'(idx) * CHUNK);
    assign last = (idx == LAST_IDX);

    // The only carry path is CHUNK bits wide; cy carries it between cycles.
    always_comb begin
        a_s                      = a_r[pos +: CHUNK];
        b_s                      = b_r[pos +: CHUNK];
        {cy_next, slice}         = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, cy};
        acc_merged               = acc;
        acc_merged[pos +: CHUNK] = slice;
    end

    // Carry into the slice MSB is recovered from its sum bit and operand bits.
    assign ovf_next = slice[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ cy_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        cy  <= c_in;
                        idx <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_merged;
                    cy  <= cy_next;
                    if (last) begin
                        idx   <= '0;
                        sum   <= acc_merged;
                        c_out <= cy_next;
                        ovf   <= ovf_next;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - self-checking bench for seq_chunk_adder
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  cin_v;
    logic [15:0] a_v [3];
    logic [15:0] b_v [3];
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [15:0] sum0;
    logic [3:0]  sum1;
    logic [3:0]  sum2;

    int n_checks = 0;
    int n_fail   = 0;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .c_in(cin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .c_out(cout_v[0]), .ovf(ovf_v[0])
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]), .c_in(cin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .c_out(cout_v[1]), .ovf(ovf_v[1])
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][3:0]), .b(b_v[2][3:0]), .c_in(cin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .c_out(cout_v[2]), .ovf(ovf_v[2])
    );

    function automatic logic [15:0] get_sum(input int d);
        if (d == 0) return sum0;
        if (d == 1) return {12'd0, sum1};
        return {12'd0, sum2};
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 16 : 4;
    endfunction

    function automatic int slices_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    // Reference: plain integer add, overflow from the two's-complement sign rule.
    function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                          input logic ci);
        longint unsigned m, s;
        logic [15:0] rs;
        logic sa, sb, ss, co, ov;
        m  = (64'd1 << w) - 64'd1;
        s  = (longint'(av) & m) + (longint'(bv) & m) + longint'(ci);
        rs = 16'(s & m);
        co = 1'((s >> w) & 64'd1);
        sa = av[w-1];
        sb = bv[w-1];
        ss = rs[w-1];
        ov = (sa == sb) && (ss != sa);
        return {ov, co, rs};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int d, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                          output int lat, output bit busy_ok);
        a_v[d]     = av;
        b_v[d]     = bv;
        cin_v[d]   = ci;
        start_v[d] = 1'b1;
        cyc();
        start_v[d] = 1'b0;
        busy_ok = (busy_v[d] === 1'b1) && (done_v[d] === 1'b0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (done_v[d] === 1'b1) begin
                if (busy_v[d] !== 1'b0) busy_ok = 1'b0;
                lat = i;
                break;
            end
            if (busy_v[d] !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
                $display("FAIL reset_flags dut%0d: busy=%b done=%b expected 0 0", d, busy_v[d], done_v[d]);
                n_fail++;
            end
            n_checks++;
            if (get_sum(d) !== 16'd0 || cout_v[d] !== 1'b0 || ovf_v[d] !== 1'b0) begin
                $display("FAIL reset_result dut%0d: sum=%h c_out=%b ovf=%b expected 0 0 0",
                         d, get_sum(d), cout_v[d], ovf_v[d]);
                n_fail++;
            end
        end
    endtask

    task automatic check_vec(input string name, input logic [15:0] av, input logic [15:0] bv,
                             input logic ci, input logic [17:0] want);
        int lat;
        bit bok;
        run_op(0, av, bv, ci, lat, bok);
        n_checks++;
        if (lat != 4) begin
            $display("FAIL %s_latency: got %0d expected 4", name, lat);
            n_fail++;
        end
        n_checks++;
        if (!bok) begin
            $display("FAIL %s_busy: busy/done overlap or gap, expected clean busy window", name);
            n_fail++;
        end
        n_checks++;
        if ({ovf_v[0], cout_v[0], sum0} !== want) begin
            $display("FAIL %s_result: got ovf=%b c_out=%b sum=%h expected ovf=%b c_out=%b sum=%h",
                     name, ovf_v[0], cout_v[0], sum0, want[17], want[16], want[15:0]);
            n_fail++;
        end
        cyc();
        n_checks++;
        if (done_v[0] !== 1'b0 || {ovf_v[0], cout_v[0], sum0} !== want) begin
            $display("FAIL %s_hold: done=%b sum=%h expected done=0 sum=%h", name, done_v[0], sum0, want[15:0]);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        check_vec("basic", 16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555});
    endtask

    task automatic test_ripple();
        check_vec("ripple", 16'hFFFF, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h0000});
    endtask

    task automatic test_overflow();
        check_vec("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
        check_vec("ovf_neg", 16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});
    endtask

    task automatic test_back_to_back();
        bit seen;
        int gap;
        a_v[0] = 16'h00FF; b_v[0] = 16'h0001; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        cyc();
        a_v[0] = 16'hAAAA;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_v[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        n_checks++;
        if (!seen || sum0 !== 16'h0100) begin
            $display("FAIL b2b_first: seen=%b sum=%h expected 1 0100", seen, sum0);
            n_fail++;
        end
        gap = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 1) start_v[0] = 1'b0;
            if (done_v[0] === 1'b1) begin
                gap = i;
                break;
            end
        end
        n_checks++;
        if (gap != 5) begin
            $display("FAIL b2b_gap: got %0d expected 5", gap);
            n_fail++;
        end
        n_checks++;
        if (sum0 !== model(16, 16'hAAAA, 16'h0001, 1'b0) >> 0 & 18'hFFFF) begin
            $display("FAIL b2b_second: got %h expected %h", sum0, 16'hAAAB);
            n_fail++;
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int dones;
        int lat;
        bit bok;
        a_v[0] = 16'h00FF; b_v[0] = 16'h0001; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || sum0 !== 16'd0) begin
            $display("FAIL rst_mid_state: busy=%b done=%b sum=%h expected 0 0 0000", busy_v[0], done_v[0], sum0);
            n_fail++;
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (done_v[0] === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", dones);
            n_fail++;
        end
        run_op(0, 16'h0003, 16'h0004, 1'b0, lat, bok);
        n_checks++;
        if (sum0 !== 16'h0007 || lat != 4) begin
            $display("FAIL rst_mid_after: sum=%h lat=%0d expected 0007 4", sum0, lat);
            n_fail++;
        end
    endtask

    task automatic test_random();
        int lat;
        bit bok;
        logic [15:0] av, bv;
        logic ci;
        logic [17:0] want;
        for (int k = 0; k < 40; k++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            ci = 1'($urandom_range(0, 1));
            want = model(16, av, bv, ci);
            for (int j = $urandom_range(0, 2); j > 0; j--) cyc();
            run_op(0, av, bv, ci, lat, bok);
            n_checks++;
            if ({ovf_v[0], cout_v[0], sum0} !== want || lat != 4 || !bok) begin
                $display("FAIL random %h+%h+%b: got ovf=%b c_out=%b sum=%h lat=%0d busy_ok=%b expected ovf=%b c_out=%b sum=%h lat=4",
                         av, bv, ci, ovf_v[0], cout_v[0], sum0, lat, bok, want[17], want[16], want[15:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_sweep();
        int lat;
        bit bok;
        logic [17:0] want;
        logic [15:0] got;
        for (int d = 1; d < 3; d++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        want = model(width_of(d), 16'(av), 16'(bv), 1'(ci));
                        run_op(d, 16'(av), 16'(bv), 1'(ci), lat, bok);
                        got = get_sum(d);
                        n_checks++;
                        if (got !== want[15:0] || cout_v[d] !== want[16] || ovf_v[d] !== want[17]
                            || lat != slices_of(d) || !bok) begin
                            $display("FAIL sweep dut%0d %0d+%0d+%0d: got ovf=%b c_out=%b sum=%h lat=%0d expected ovf=%b c_out=%b sum=%h lat=%0d",
                                     d, av, bv, ci, ovf_v[d], cout_v[d], got, lat,
                                     want[17], want[16], want[15:0], slices_of(d));
                            n_fail++;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start_v = '0;
        cin_v   = '0;
        for (int d = 0; d < 3; d++) begin
            a_v[d] = '0;
            b_v[d] = '0;
        end
        cyc();
        cyc();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
